rank_filter3x3_pipe: RTL and testbench
======================================

// Module: rank_filter3x3_pipe
// PURPOSE
//  Parametrised, fully pipelined 3x3 rank filter; successor to the fixed 16-bit median filter.
//  Accepts one packed 3x3 window per cycle from the window generator and returns median, min or max.
//  Selection is per window. Latency is fixed; valid/ready handshakes on both sides give backpressure.
//  Sits between the line-buffer window generator and the output stream packer.
// PARAMETERS
//  DATA_W  16  pixel width in bits (>=2)
//  SIGNED  0   1: compare as two's-complement signed; 0: unsigned
//  CNT_W   16  width of processed-window counter
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         reset, asynchronous, active-low
//  clear      in   1         synchronous flush of pipeline valids and counter
//  in_valid   in   1         window valid
//  in_ready   out  1         filter can accept window this cycle
//  in_win     in   9*DATA_W  window, row-major; element k at [k*DATA_W +: DATA_W], k=0..8
//  in_mode    in   2         0=median, 1=min, 2=max, 3=median (reserved)
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts result
//  out_data   out  DATA_W    filtered pixel
//  out_mode   out  2         mode that produced out_data
//  busy       out  1         any pipeline stage holds a valid window
//  win_count  out  CNT_W     count of output handshakes, wraps to 0
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, out_valid=0, out_data=0, out_mode=0, win_count=0, busy=0.
//  - Global advance enable adv = !out_valid | out_ready; in_ready = adv (combinational, no in_valid dependency).
//  - Input accepted when in_valid & in_ready; out handshake when out_valid & out_ready.
//  - Pipeline stages, all registered, advance only when adv=1; valid bit and mode travel with data.
//    S1: per column c=0..2 over elements {c, c+3, c+6}: hi_c=max, md_c=med, lo_c=min.
//    S2: p=max(lo0,lo1,lo2), q=med(md0,md1,md2), r=min(hi0,hi1,hi2),
//        gmin=min(lo0,lo1,lo2), gmax=max(hi0,hi1,hi2).
//    S3: out_data = median: med(p,q,r); min: gmin; max: gmax.
//  - Latency: result on out_valid exactly 3 cycles after acceptance when adv stays 1.
//  - Throughput 1 window/cycle. When adv=0 every stage holds (bubbles are not squeezed).
//  - Stalled output: out_data/out_mode/out_valid stable until the out handshake.
//    in_win/in_mode are not sampled while in_ready=0.
//  - Bubble advancing: stage valid=0; its data regs may hold stale values; out_data is don't-care when out_valid=0.
//  - Ties: equal values legal; result equals the tied value; comparators use >= / <= consistently.
//  - Compare type from SIGNED only; no width growth, outputs exactly DATA_W bits.
//  - win_count += 1 per out handshake; CNT_W all-ones + 1 -> 0.
//  - clear=1: next edge zeroes all stage valids, out_valid, win_count; in_ready=1 that cycle, but an input
//    offered with clear=1 is dropped. clear takes priority over advance and counting.
//  - rst_n low mid-operation: in-flight windows discarded, outputs to reset values immediately.
//  - busy = OR of S1,S2,S3 valids.
// TESTING
//  1 Win {1..9} in order, mode 0, out_ready=1 -> out_data=5, out_valid 3 cycles after accept, win_count=1.
//  2 Win {9,3,7,1,8,2,6,4,5}, modes 1,2,0 back-to-back -> outputs 1,9,5 on consecutive cycles, out_mode 1,2,0.
//  3 Backpressure: 4 windows streamed, out_ready=0 for 5 cycles -> in_ready=0 after pipe full,
//    out_data held, no loss/duplication, order preserved after release.
//  4 SIGNED=1, DATA_W=8: win {-128,-1,0,1,127,-5,5,-2,2} mode 0 -> 0; mode 1 -> -128 (0x80); mode 2 -> 127.
//  5 All-equal window 0xABCD, all modes -> 0xABCD; win_count wraps from 0xFFFF to 0 (preloaded by streaming).
//  6 rst_n pulse with 2 windows in flight -> out_valid=0, busy=0, win_count=0 async; clear gives same sync.

Source files
------------

// File: rtl/rank_filter3x3_pipe.sv
// Three-stage pipelined 3x3 rank filter (median / min / max) with a valid/ready handshake on both sides.
// Column sort, then cross-column rank extraction, then final selection into the output register.
module rank_filter3x3_pipe #(
  parameter int DATA_W = 16,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [9*DATA_W-1:0] in_win,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_mode,
  output logic                busy,
  output logic [CNT_W-1:0]    win_count
);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic logic ge(input pix_t a, input pix_t b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED) return sa >= sb;
    else        return a >= b;
  endfunction

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return ge(a, b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return ge(a, b) ? b : a;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic w_adv;
  pix_t w_e  [9];
  pix_t w_hi [3];
  pix_t w_md [3];
  pix_t w_lo [3];

  logic       r_vld_p1, r_vld_p2, r_vld_p3;
  logic [1:0] r_mode_p1, r_mode_p2, r_mode_p3;
  pix_t       r_hi_p1 [3];
  pix_t       r_md_p1 [3];
  pix_t       r_lo_p1 [3];
  pix_t       r_p_p2, r_q_p2, r_r_p2, r_gmin_p2, r_gmax_p2;
  pix_t       r_data_p3;
  logic [CNT_W-1:0] r_cnt;

  // Whole pipe moves as one unit; a stalled output freezes every stage, bubbles included.
  assign w_adv     = !r_vld_p3 || out_ready;
  assign in_ready  = w_adv || clear;
  assign out_valid = r_vld_p3;
  assign out_data  = r_data_p3;
  assign out_mode  = r_mode_p3;
  assign busy      = r_vld_p1 || r_vld_p2 || r_vld_p3;
  assign win_count = r_cnt;

  always_comb begin
    for (int k = 0; k < 9; k++) w_e[k] = in_win[k*DATA_W +: DATA_W];
    for (int c = 0; c < 3; c++) begin
      w_hi[c] = max3(w_e[c], w_e[c+3], w_e[c+6]);
      w_md[c] = med3(w_e[c], w_e[c+3], w_e[c+6]);
      w_lo[c] = min3(w_e[c], w_e[c+3], w_e[c+6]);
    end
  end

  // Control path: valids and counter; clear overrides advance and counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_cnt    <= '0;
    end else if (clear) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_adv) begin
        r_vld_p1 <= in_valid;
        r_vld_p2 <= r_vld_p1;
        r_vld_p3 <= r_vld_p2;
      end
      if (r_vld_p3 && out_ready) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // S1: per-column sort
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mode_p1 <= in_mode;
      for (int c = 0; c < 3; c++) begin
        r_hi_p1[c] <= w_hi[c];
        r_md_p1[c] <= w_md[c];
        r_lo_p1[c] <= w_lo[c];
      end
    end
  end

  // S2: cross-column rank candidates and global extremes
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_mode_p2 <= r_mode_p1;
      r_p_p2    <= max3(r_lo_p1[0], r_lo_p1[1], r_lo_p1[2]);
      r_q_p2    <= med3(r_md_p1[0], r_md_p1[1], r_md_p1[2]);
      r_r_p2    <= min3(r_hi_p1[0], r_hi_p1[1], r_hi_p1[2]);
      r_gmin_p2 <= min3(r_lo_p1[0], r_lo_p1[1], r_lo_p1[2]);
      r_gmax_p2 <= max3(r_hi_p1[0], r_hi_p1[1], r_hi_p1[2]);
    end
  end

  // S3: mode select into the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_p3 <= '0;
      r_mode_p3 <= 2'd0;
    end else if (w_adv) begin
      r_mode_p3 <= r_mode_p2;
      case (r_mode_p2)
        2'd1:    r_data_p3 <= r_gmin_p2;
        2'd2:    r_data_p3 <= r_gmax_p2;
        default: r_data_p3 <= med3(r_p_p2, r_q_p2, r_r_p2);
      endcase
    end
  end

endmodule

// File: tb/tb_rank_filter3x3_pipe.sv
// Directed bench for rank_filter3x3_pipe: 16-bit unsigned instance A, 8-bit signed instance B
// (4-bit window counter on B so the wrap is reached in a handful of windows).
module tb_rank_filter3x3_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [143:0] a_in_win;
  logic [1:0]   a_in_mode, a_out_mode;
  logic [15:0]  a_out_data, a_win_count;

  logic         b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [71:0]  b_in_win;
  logic [1:0]   b_in_mode, b_out_mode;
  logic [7:0]   b_out_data;
  logic [3:0]   b_win_count;

  int n_cmp, n_err;

  rank_filter3x3_pipe #(.DATA_W(16), .SIGNED(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_win(a_in_win), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode),
    .busy(a_busy), .win_count(a_win_count)
  );

  rank_filter3x3_pipe #(.DATA_W(8), .SIGNED(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_win(b_in_win), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
    .busy(b_busy), .win_count(b_win_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] pk16(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [71:0] pk8(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [143:0] seq16(input int base);
    logic [143:0] w;
    for (int k = 0; k < 9; k++) w[k*16 +: 16] = 16'(base + k + 1);
    return w;
  endfunction

  initial begin
    int sent, got;
    logic hs_in, hs_out;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; clear = 1'b0; b_clear = 1'b0;
    a_in_valid = 1'b0; a_in_win = '0; a_in_mode = 2'd0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_win = '0; b_in_mode = 2'd0; b_out_ready = 1'b1;

    #12;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_count", a_win_count, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_mode", a_out_mode, 0);
    chk("rst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Test 1: ordered window, median, 3-cycle latency
    a_in_valid = 1'b1; a_in_win = pk16(1, 2, 3, 4, 5, 6, 7, 8, 9); a_in_mode = 2'd0;
    #1 chk("t1_in_ready", a_in_ready, 1);
    step();
    a_in_valid = 1'b0;
    chk("t1_lat1", a_out_valid, 0);
    chk("t1_busy", a_busy, 1);
    step();
    chk("t1_lat2", a_out_valid, 0);
    step();
    chk("t1_valid", a_out_valid, 1);
    chk("t1_data", a_out_data, 5);
    chk("t1_mode", a_out_mode, 0);
    step();
    chk("t1_drain", a_out_valid, 0);
    chk("t1_count", a_win_count, 1);

    // Test 2: shuffled window, modes 1,2,0 back-to-back
    a_in_valid = 1'b1; a_in_win = pk16(9, 3, 7, 1, 8, 2, 6, 4, 5);
    a_in_mode = 2'd1; step();
    a_in_mode = 2'd2; step();
    a_in_mode = 2'd0; step();
    a_in_valid = 1'b0;
    chk("t2_v0", a_out_valid, 1);
    chk("t2_min", a_out_data, 1);
    chk("t2_mode1", a_out_mode, 1);
    step();
    chk("t2_max", a_out_data, 9);
    chk("t2_mode2", a_out_mode, 2);
    step();
    chk("t2_med", a_out_data, 5);
    chk("t2_mode0", a_out_mode, 0);
    step();
    chk("t2_drain", a_out_valid, 0);
    chk("t2_count", a_win_count, 4);

    // Test 3: backpressure, out_ready low for cycles 2..6
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      a_in_valid = (sent < 4);
      a_in_win = seq16(sent * 10);
      a_in_mode = 2'd0;
      a_out_ready = !(cyc >= 2 && cyc <= 6);
      #1;
      hs_in = a_in_valid && a_in_ready;
      hs_out = a_out_valid && a_out_ready;
      if (cyc >= 3 && cyc <= 6) begin
        chk("t3_stall_in_ready", a_in_ready, 0);
        chk("t3_stall_valid", a_out_valid, 1);
        chk("t3_stall_hold", a_out_data, 5);
      end
      if (hs_out) begin
        chk("t3_order", a_out_data, got * 10 + 5);
        got++;
      end
      step();
      if (hs_in) sent++;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    chk("t3_got", got, 4);
    chk("t3_sent", sent, 4);
    #1 chk("t3_no_dup", a_out_valid, 0);
    chk("t3_count", a_win_count, 8);
    step();

    // Test 5a: all-equal window, all modes
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i < 4);
      a_in_win = pk16(16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD,
                      16'hABCD, 16'hABCD, 16'hABCD, 16'hABCD);
      a_in_mode = 2'(i);
      step();
      if (i >= 2 && i <= 5) begin
        chk("t5_valid", a_out_valid, 1);
        chk("t5_tie_data", a_out_data, 16'hABCD);
        chk("t5_mode", a_out_mode, 32'(i - 2));
      end
    end
    a_in_valid = 1'b0;
    chk("t5_count", a_win_count, 12);

    // Test 4: signed 8-bit window, modes 0,1,2,3
    b_in_win = pk8(8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'hFB, 8'h05, 8'hFE, 8'h02);
    for (int i = 0; i < 7; i++) begin
      b_in_valid = (i < 4);
      b_in_mode = 2'(i);
      step();
      if (i == 2) chk("t4_med", b_out_data, 8'h00);
      if (i == 3) chk("t4_min", b_out_data, 8'h80);
      if (i == 4) chk("t4_max", b_out_data, 8'h7F);
      if (i == 5) chk("t4_mode3_med", b_out_data, 8'h00);
      if (i >= 2 && i <= 5) chk("t4_valid", b_out_valid, 1);
    end
    b_in_valid = 1'b0;
    chk("t4_count", b_win_count, 4);

    // Test 5b: counter wrap on the 4-bit instance
    b_in_win = pk8(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    b_in_mode = 2'd0;
    for (int i = 0; i < 15; i++) begin
      b_in_valid = (i < 11);
      step();
    end
    chk("t5_cnt_max", b_win_count, 4'hF);
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_cnt_wrap", b_win_count, 0);

    // Test 6: async reset with windows in flight
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_win = seq16(20); a_in_mode = 2'd0;
    step(); step();
    a_in_valid = 1'b0;
    step();
    chk("t6_pre_valid", a_out_valid, 1);
    chk("t6_pre_busy", a_busy, 1);
    chk("t6_pre_count", a_win_count, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", a_out_valid, 0);
    chk("t6_rst_busy", a_busy, 0);
    chk("t6_rst_count", a_win_count, 0);
    chk("t6_rst_data", a_out_data, 0);
    chk("t6_rst_b_count", b_win_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    step();

    // Test 6b: synchronous clear
    a_in_valid = 1'b1; step();
    a_in_valid = 1'b0;
    step(); step(); step();
    chk("t6c_count1", a_win_count, 1);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; step(); step();
    a_in_valid = 1'b0; step();
    chk("t6c_pre_valid", a_out_valid, 1);
    clear = 1'b1; a_in_valid = 1'b1;
    #1 chk("t6c_in_ready", a_in_ready, 1);
    step();
    clear = 1'b0; a_in_valid = 1'b0;
    chk("t6c_valid", a_out_valid, 0);
    chk("t6c_busy", a_busy, 0);
    chk("t6c_count", a_win_count, 0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6c_dropped", a_out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
